counter_seq: RTL and testbench
==============================

# counter_seq

Sequencing controller for the 4-bit loadable counter datapath (enable, mode 0 = count up, mode 1 = parallel load). It drives the counter's `enb`/`modo`/`data` inputs and watches its `Q` so the counter runs a programmable modulo sequence `start_val..term` (e.g. 0..3) without any external reset feedback. It supports one-shot and free-running operation, pause/resume and a terminal-count strobe. It sits between the system control logic and one counter instance on the same clock and reset.

## Interface
- `TC_REG`, default 0: 0 = `tc` is decoded combinationally in RUN; 1 = `tc` is registered, one cycle later.
- `clk` in 1: rising-edge clock shared with the counter.
- `rst` in 1: asynchronous, active-low reset. Asserting low immediately forces the reset state; the release is synchronous to `clk` by the system. The same net resets the counter.
- `start` in 1: single-cycle request; starts from IDLE/DONE or resumes from PAUSE.
- `stop` in 1: single-cycle request; pauses RUN or aborts PAUSE/DONE to IDLE.
- `oneshot` in 1: sampled with `start` in IDLE/DONE; 1 = stop after the first `term`.
- `start_val` in 4: initial/reload count, sampled with `start` in IDLE/DONE.
- `term` in 4: terminal count, sampled with `start` in IDLE/DONE.
- `cnt_q` in 4: counter `Q` feedback.
- `cnt_enb` out 1: counter enable.
- `cnt_modo` out 1: counter mode (0 count, 1 load).
- `cnt_data` out 4: counter parallel data.
- `busy` out 1: high in LOAD or RUN.
- `paused` out 1: high in PAUSE.
- `done` out 1: high in DONE.
- `tc` out 1: terminal-count strobe.
- `wraps` out 8: completed-period count. Present only with `COUNTER_SEQ_WRAPCNT_EN`.

## Operation
- Reset values: state IDLE; `sv_r`, `term_r`, `os_r` all 0; all outputs 0; `wraps` 0.
- The FSM has five states: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE:
  - `cnt_enb` = 0.
  - `start` and not `stop` → latch `start_val`, `term`, `oneshot`; go to LOAD.
- LOAD:
  - Outputs: `cnt_enb` = 1, `cnt_modo` = 1, `cnt_data` = `sv_r`.
  - Always goes to RUN next cycle; `start`/`stop` are ignored.
- RUN:
  - Default outputs: `cnt_enb` = 1, `cnt_modo` = 0.
  - Hit: `cnt_q` == `term_r` (tc condition).
  - Hit, `os_r` = 0: `cnt_modo` = 1, `cnt_data` = `sv_r` (reload on this edge); stay in RUN.
  - Hit, `os_r` = 1: `cnt_enb` = 0 (hold `term_r`); go to DONE.
  - `stop` → `cnt_enb` = 0 this cycle; go to PAUSE. This takes priority over the hit: no reload and no DONE entry. `tc` still reflects the hit condition.
  - `start` is ignored in RUN.
- PAUSE:
  - `cnt_enb` = 0; the count is held.
  - `stop` → IDLE. `stop` wins when `start` and `stop` arrive together.
  - `start` alone → RUN, with no reload and no new config sampling.
- DONE:
  - `cnt_enb` = 0; the count holds `term_r`.
  - `start` → sample new config; go to LOAD.
  - `stop` → IDLE. `stop` wins when both arrive together.
- `cnt_data` = `sv_r` in every state; it only matters when `cnt_modo` = 1.
- Arithmetic: all compares are 4-bit unsigned equality. Period = ((`term_r` − `sv_r`) mod 16) + 1 cycles. If `term_r` < `sv_r`, the counter wraps 15→0 naturally. If `term_r` = `sv_r`, the period is 1 and the counter reloads every cycle.
- Reset in any state: immediate return to IDLE, all outputs 0. The counter value after reset is irrelevant because LOAD always precedes RUN.

## Timing
- `start` sampled at edge N: LOAD during N..N+1; counter holds `sv_r` after edge N+1; RUN from N+1.
- First `tc`:
  - `TC_REG`=0: `tc` is high in the RUN cycle where `cnt_q` == `term_r`. It is a one-cycle pulse per period; for a period of 1 it stays high continuously.
  - `TC_REG`=1: `tc` is delayed by exactly one cycle and is 0 at reset.
- One-shot: DONE is entered at the edge following the `tc` cycle; `done` is high from that edge.
- `stop` in RUN at edge M: the counter does not advance at edge M; `paused` is high from M.
- Resume: `start` at edge P returns to RUN; counting resumes at edge P+1 from the held value.
- Throughput: one count per cycle in RUN; no idle cycles at the wrap.

## Configuration
- `COUNTER_SEQ_WRAPCNT_EN` defined:
  - 8-bit `wraps` port and register.
  - Increments at each edge where the tc condition holds in RUN, including the one-shot final hit; saturates at 255.
  - Cleared to 0 on LOAD entry and on reset.
- Not defined: the `wraps` port and its register are absent; all other behaviour is identical.

## Test plan
- Mod-4 free run: `sv`=0, `term`=3, `oneshot`=0, `start` → `cnt_q` = 0,1,2,3,0,1,…; `tc` high every 4th cycle when `cnt_q`=3; `busy`=1.
- One-shot wrap-around: `sv`=14, `term`=1, `oneshot`=1 → `cnt_q` 14,15,0,1; `tc` once; `done`=1; `cnt_q` holds 1; `wraps`=1 with macro.
- Pause/resume: `sv`=0, `term`=9; `stop` when `cnt_q`=5 → `paused`, `cnt_q` stays 5 for 3 cycles; `start` → 6,7,…; no reload.
- Simultaneous `start`+`stop` in PAUSE → IDLE; `start` in RUN ignored; `stop` on a `tc` cycle → PAUSE at 9 without reload.
- Degenerate period: `sv`=`term`=7 → `cnt_modo`=1 every RUN cycle, `cnt_q`=7, `tc` continuously high (`TC_REG`=0).
- Asynchronous reset mid-RUN (`rst` low between edges) → all outputs 0 immediately; after release, state is IDLE and `wraps`=0.

Source files
------------

// File: rtl/counter_seq.sv
// Sequencing controller for a 4-bit loadable counter: runs start_val..term modulo sequences, one-shot or free-running, with pause/resume.
// Latency: LOAD one cycle after start, count visible the next; tc combinational (TC_REG=0) or one cycle later (TC_REG=1).
// Backpressure: none; start/stop are single-cycle requests. Optional wrap counter enabled by COUNTER_SEQ_WRAPCNT_EN.
module counter_seq #(
    parameter bit TC_REG = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       oneshot,
    input  logic [3:0] start_val,
    input  logic [3:0] term,
    input  logic [3:0] cnt_q,
    output logic       cnt_enb,
    output logic       cnt_modo,
    output logic [3:0] cnt_data,
    output logic       busy,
    output logic       paused,
    output logic       done,
    output logic       tc
`ifdef COUNTER_SEQ_WRAPCNT_EN
    ,
    output logic [7:0] wraps
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sv_q, sv_d;
    logic [3:0] term_q, term_d;
    logic       os_q, os_d;
    logic       cfg_ld;
    logic       hit;

    assign hit = (state_q == S_RUN) && (cnt_q == term_q);

    always_comb begin
        state_d  = state_q;
        cfg_ld   = 1'b0;
        cnt_enb  = 1'b0;
        cnt_modo = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    cfg_ld  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_enb  = 1'b1;
                cnt_modo = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                cnt_enb = 1'b1;
                // A pause request beats the terminal hit: no reload, no DONE.
                if (stop) begin
                    cnt_enb = 1'b0;
                    state_d = S_PAUSE;
                end else if (hit) begin
                    if (os_q) begin
                        cnt_enb = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cnt_modo = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    cfg_ld  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sv_d   = sv_q;
        term_d = term_q;
        os_d   = os_q;
        if (cfg_ld) begin
            sv_d   = start_val;
            term_d = term;
            os_d   = oneshot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sv_q    <= 4'd0;
            term_q  <= 4'd0;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sv_q    <= sv_d;
            term_q  <= term_d;
            os_q    <= os_d;
        end
    end

    assign cnt_data = sv_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign paused   = (state_q == S_PAUSE);
    assign done     = (state_q == S_DONE);

    generate
        if (TC_REG) begin : g_tc_reg
            logic tc_q, tc_d;
            assign tc_d = hit;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tc_q <= 1'b0;
                end else begin
                    tc_q <= tc_d;
                end
            end
            assign tc = tc_q;
        end else begin : g_tc_comb
            assign tc = hit;
        end
    endgenerate

`ifdef COUNTER_SEQ_WRAPCNT_EN
    logic [7:0] wraps_q, wraps_d;

    always_comb begin
        wraps_d = wraps_q;
        if (cfg_ld) begin
            wraps_d = 8'd0;
        end else if (hit && (wraps_q != 8'hFF)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wraps_q <= 8'd0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign wraps = wraps_q;
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: behavioural counter plus a count-level reference model, checked every negedge,
// and directed scenarios with literal expectations.
module tb_counter_seq;

    localparam bit TC_REG = 1'b0;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_PAUSE = 3;
    localparam int P_DONE  = 4;

    logic       clk;
    logic       rst;
    logic       start, stop, oneshot;
    logic [3:0] start_val, term;
    logic [3:0] cnt_q;
    logic       cnt_enb, cnt_modo;
    logic [3:0] cnt_data;
    logic       busy, paused, done, tc;
`ifdef COUNTER_SEQ_WRAPCNT_EN
    logic [7:0] wraps;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    counter_seq #(.TC_REG(TC_REG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .start_val (start_val),
        .term      (term),
        .cnt_q     (cnt_q),
        .cnt_enb   (cnt_enb),
        .cnt_modo  (cnt_modo),
        .cnt_data  (cnt_data),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .tc        (tc)
`ifdef COUNTER_SEQ_WRAPCNT_EN
        ,
        .wraps     (wraps)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The 4-bit loadable counter the controller drives; shares clock and reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 4'd0;
        else if (cnt_enb) cnt_q <= cnt_modo ? cnt_data : cnt_q + 4'd1;
    end

    // Reference model: tracks the expected count value directly.
    int         m_ph;
    logic [3:0] m_cnt, m_sv, m_term;
    logic       m_os, m_tcd;
    logic [7:0] m_wraps;
    logic       m_tc_now;

    assign m_tc_now = (m_ph == P_RUN) && (m_cnt == m_term);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= P_IDLE; m_cnt <= 4'd0; m_sv <= 4'd0; m_term <= 4'd0;
            m_os <= 1'b0; m_tcd <= 1'b0; m_wraps <= 8'd0;
        end else begin
            m_tcd <= m_tc_now;
            if (m_tc_now && m_wraps != 8'd255) m_wraps <= m_wraps + 8'd1;
            if (m_ph == P_IDLE || m_ph == P_DONE) begin
                if (stop && m_ph == P_DONE) m_ph <= P_IDLE;
                else if (start && !stop) begin
                    m_sv <= start_val; m_term <= term; m_os <= oneshot;
                    m_wraps <= 8'd0; m_ph <= P_LOAD;
                end
            end else if (m_ph == P_LOAD) begin
                m_cnt <= m_sv; m_ph <= P_RUN;
            end else if (m_ph == P_RUN) begin
                if (stop) m_ph <= P_PAUSE;
                else if (m_cnt == m_term) begin
                    if (m_os) m_ph <= P_DONE;
                    else m_cnt <= m_sv;
                end else m_cnt <= m_cnt + 4'd1;
            end else begin
                if (stop) m_ph <= P_IDLE;
                else if (start) m_ph <= P_RUN;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("m_busy", busy, (m_ph == P_LOAD || m_ph == P_RUN));
            chk("m_paused", paused, (m_ph == P_PAUSE));
            chk("m_done", done, (m_ph == P_DONE));
            chk("m_tc", tc, TC_REG ? m_tcd : m_tc_now);
            chk("m_cnt", cnt_q, m_cnt);
`ifdef COUNTER_SEQ_WRAPCNT_EN
            chk("m_wraps", wraps, m_wraps);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        step(); stop = 1'b1;
        step(); stop = 1'b0;
    endtask

    initial begin
        logic [3:0] seq_os [4];
        seq_os[0] = 4'd14; seq_os[1] = 4'd15; seq_os[2] = 4'd0; seq_os[3] = 4'd1;

        rst = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
        start_val = 4'd0; term = 4'd0;
        #1;
        chk("rst_outs", {cnt_enb, cnt_modo, cnt_data, busy, paused, done, tc}, 0);
        step(); step();
        rst = 1'b1;

        // Mod-4 free run
        start_val = 4'd0; term = 4'd3; oneshot = 1'b0;
        pulse_start();
        @(negedge clk);
        chk("load_modo", cnt_modo, 1);
        chk("load_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mod4_cnt", cnt_q, i % 4);
            chk("mod4_tc", tc, (i % 4) == 3);
        end
        pulse_stop();
        pulse_stop();

        // One-shot with wrap-around
        start_val = 4'd14; term = 4'd1; oneshot = 1'b1;
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("os_cnt", cnt_q, seq_os[i]);
            chk("os_tc", tc, i == 3);
        end
        @(negedge clk);
        chk("os_done", done, 1);
        chk("os_busy", busy, 0);
        chk("os_tc_after", tc, 0);
        @(negedge clk);
        chk("os_hold", cnt_q, 1);
`ifdef COUNTER_SEQ_WRAPCNT_EN
        chk("os_wraps", wraps, 1);
`endif

        // Pause/resume from DONE with sv=0, term=9
        start_val = 4'd0; term = 4'd9; oneshot = 1'b0;
        pulse_start();
        repeat (6) step();
        chk("pre_stop_cnt", cnt_q, 5);
        stop = 1'b1;
        step(); stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pause_cnt", cnt_q, 5);
            chk("pause_flag", paused, 1);
            chk("pause_enb", cnt_enb, 0);
        end
        pulse_start();
        @(negedge clk);
        chk("resume_cnt0", cnt_q, 5);
        chk("resume_busy", busy, 1);
        @(negedge clk);
        chk("resume_cnt1", cnt_q, 6);
        @(negedge clk);
        chk("resume_cnt2", cnt_q, 7);

        // start in RUN ignored; stop on tc cycle
        step(); start = 1'b1;
        step(); start = 1'b0;
        chk("tc_cycle_cnt", cnt_q, 9);
        chk("tc_cycle_tc", tc, 1);
        stop = 1'b1;
        #1;
        chk("stop_tc_enb", cnt_enb, 0);
        chk("stop_tc_tc", tc, 1);
        step(); stop = 1'b0;
        @(negedge clk);
        chk("stop_tc_paused", paused, 1);
        chk("stop_tc_noreload", cnt_q, 9);

        // start+stop together in PAUSE
        step(); start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("both_idle", {busy, paused, done}, 0);

        // Degenerate period of 1
        start_val = 4'd7; term = 4'd7; oneshot = 1'b0;
        pulse_start();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("deg_cnt", cnt_q, 7);
            chk("deg_modo", cnt_modo, 1);
            chk("deg_tc", tc, 1);
        end

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_outs", {cnt_enb, cnt_modo, cnt_data, busy, paused, done, tc}, 0);
        step(); step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {busy, paused, done, tc}, 0);
`ifdef COUNTER_SEQ_WRAPCNT_EN
        chk("post_rst_wraps", wraps, 0);
`endif

        // Short one-shot after reset
        start_val = 4'd5; term = 4'd6; oneshot = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        chk("final_done", done, 1);
        chk("final_cnt", cnt_q, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
